// File: rtl/fdiv_period_meter_if.sv
// Result port of the period meter: valid/ready handshake plus period and status flags.
interface fdiv_period_meter_if #(
    parameter int CNT_W = 8
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] meas_period;
    logic             meas_sat;
    logic             meas_missed;

    modport master (
        output meas_valid, meas_period, meas_sat, meas_missed,
        input  meas_ready
    );

    modport slave (
        input  meas_valid, meas_period, meas_sat, meas_missed,
        output meas_ready
    );
endinterface

// File: rtl/fdiv_period_meter.sv
// Counts clk cycles between rising edges of a divided clock and offers each period on a
// valid/ready port. Define FDIV_PERIOD_METER_LOCK_EN to build the lock detector.
module fdiv_period_meter #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 16,
    parameter int LOCK_TOL   = 0,
    parameter int LOCK_CNT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_in_i,
    fdiv_period_meter_if.master  meas,
    output logic                 locked_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (CNT_W < 4 || CNT_W > 16 || LOCK_CNT < 1 || LOCK_CNT > 15 ||
        LOCK_TOL < 0 || EXP_PERIOD < 2) begin : g_bad_param
        $error("fdiv_period_meter: parameter out of range");
    end

    typedef enum logic [1:0] {ARM, RUN, HOLD} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d, sat_q, sat_d, missed_q, missed_d;
    logic             rise, xfer, capture;

    assign rise    = s2_q & ~s3_q;
    assign xfer    = valid_q & meas.meas_ready;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= ARM;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            s1_q     <= div_in_i;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = valid_q;
        sat_d    = sat_q;
        missed_d = missed_q;
        capture  = 1'b0;
        case (state_q)
            ARM: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    capture = 1'b1;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_inc;
                if (xfer) begin
                    valid_d  = 1'b0;
                    missed_d = 1'b0;
                    state_d  = RUN;
                end
                // A rise landing on the transfer edge refills the slot instead of being dropped
                if (rise) begin
                    cnt_d = CNT_ONE;
                    if (xfer) begin
                        capture = 1'b1;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        missed_d = 1'b1;
                    end
                end
            end
            default: state_d = ARM;
        endcase
        if (capture) begin
            period_d = cnt_q;
            sat_d    = (cnt_q == CNT_MAX);
        end
    end

    assign meas.meas_valid  = valid_q;
    assign meas.meas_period = period_q;
    assign meas.meas_sat    = sat_q;
    assign meas.meas_missed = missed_q;

`ifdef FDIV_PERIOD_METER_LOCK_EN
    logic        meas_evt, in_tol;
    logic [31:0] dev;
    logic [3:0]  run_q;
    logic        locked_q;

    // Dropped periods in HOLD are judged too, so lock tracks every edge seen
    assign meas_evt = rise & (state_q != ARM);
    assign dev      = (32'(cnt_q) >= 32'(EXP_PERIOD)) ? 32'(cnt_q) - 32'(EXP_PERIOD)
                                                      : 32'(EXP_PERIOD) - 32'(cnt_q);
    assign in_tol   = (cnt_q != CNT_MAX) && (dev <= 32'(LOCK_TOL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= '0;
            locked_q <= 1'b0;
        end else if (meas_evt) begin
            if (in_tol) begin
                if (run_q != 4'hf) run_q <= run_q + 4'd1;
                if (({1'b0, run_q} + 5'd1) >= 5'(LOCK_CNT)) locked_q <= 1'b1;
            end else begin
                run_q    <= '0;
                locked_q <= 1'b0;
            end
        end
    end

    assign locked_o = locked_q;
`else
    assign locked_o = 1'b0;
`endif
endmodule

// File: tb/tb_fdiv_period_meter.sv
// Directed bench for fdiv_period_meter: an 8-bit and a 4-bit instance share one stimulus.
module tb_fdiv_period_meter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic div = 1'b0;
    logic ready = 1'b0;
    logic locked8, locked4;
    int   nchk = 0;
    int   nbad = 0;

    typedef struct {
        logic [7:0] p;
        logic       s;
        logic       m;
        logic       l;
    } rec_t;

    rec_t q8[$];
    rec_t q4[$];

    fdiv_period_meter_if #(.CNT_W(8)) m8 ();
    fdiv_period_meter_if #(.CNT_W(4)) m4 ();

    assign m8.meas_ready = ready;
    assign m4.meas_ready = ready;

    fdiv_period_meter #(.CNT_W(8), .EXP_PERIOD(16), .LOCK_TOL(0), .LOCK_CNT(4)) dut8 (
        .clk(clk), .rst(rst), .div_in_i(div), .meas(m8.master), .locked_o(locked8)
    );

    fdiv_period_meter #(.CNT_W(4), .EXP_PERIOD(16), .LOCK_TOL(0), .LOCK_CNT(4)) dut4 (
        .clk(clk), .rst(rst), .div_in_i(div), .meas(m4.master), .locked_o(locked4)
    );

    always #5 clk = ~clk;

    // Transfers are logged mid-cycle, where valid/ready are settled before the accepting edge
    always @(negedge clk) begin
        rec_t r8, r4;
        if (m8.meas_valid && m8.meas_ready) begin
            r8.p = m8.meas_period; r8.s = m8.meas_sat; r8.m = m8.meas_missed; r8.l = locked8;
            q8.push_back(r8);
        end
        if (m4.meas_valid && m4.meas_ready) begin
            r4.p = 8'(m4.meas_period); r4.s = m4.meas_sat; r4.m = m4.meas_missed; r4.l = locked4;
            q4.push_back(r4);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nbad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic period_t(input int n);
        div = 1'b1;
        idle(n / 2);
        div = 1'b0;
        idle(n - n / 2);
    endtask

    task automatic do_reset();
        div   = 1'b0;
        ready = 1'b0;
        rst   = 1'b1;
        idle(2);
        rst = 1'b0;
        q8.delete();
        q4.delete();
        tick();
    endtask

    initial begin
        int exp_p[7];
        int exp_l[7];
        exp_p = '{16, 16, 16, 16, 16, 17, 16};
`ifdef FDIV_PERIOD_METER_LOCK_EN
        exp_l = '{0, 0, 0, 1, 1, 0, 0};
`else
        exp_l = '{0, 0, 0, 0, 0, 0, 0};
`endif

        // reset values
        rst = 1'b1;
        #1;
        chk("rst_valid", m8.meas_valid, 0);
        chk("rst_period", m8.meas_period, 0);
        chk("rst_missed", m8.meas_missed, 0);
        chk("rst_locked", locked8, 0);

        // steady /16 train with ready held high, one 17-cycle period injected
        do_reset();
        ready = 1'b1;
        repeat (5) period_t(16);
        period_t(17);
        period_t(16);
        period_t(16);
        idle(6);
        chk("t1_count", q8.size(), 7);
        for (int i = 0; i < 7 && i < q8.size(); i++) begin
            chk($sformatf("t1_period[%0d]", i), q8[i].p, exp_p[i]);
            chk($sformatf("t1_sat[%0d]", i), q8[i].s, 0);
            chk($sformatf("t1_missed[%0d]", i), q8[i].m, 0);
            chk($sformatf("t1_locked[%0d]", i), q8[i].l, exp_l[i]);
        end

        // consumer stalls for 40 cycles: first result held, one drop flagged
        do_reset();
        fork
            repeat (5) period_t(16);
            begin
                idle(40);
                ready = 1'b1;
            end
        join
        idle(6);
        chk("t2_count", q8.size(), 3);
        if (q8.size() == 3) begin
            chk("t2_p0", q8[0].p, 16);
            chk("t2_m0", q8[0].m, 1);
            chk("t2_p1", q8[1].p, 16);
            chk("t2_m1", q8[1].m, 0);
            chk("t2_m2", q8[2].m, 0);
        end
        chk("t2_missed_end", m8.meas_missed, 0);

        // high for 30 cycles then a short pulse: 4-bit counter saturates
        do_reset();
        ready = 1'b1;
        div = 1'b1;
        idle(30);
        div = 1'b0;
        idle(2);
        div = 1'b1;
        idle(2);
        div = 1'b0;
        idle(6);
        chk("t3_count4", q4.size(), 1);
        chk("t3_count8", q8.size(), 1);
        if (q4.size() == 1) begin
            chk("t3_p4", q4[0].p, 15);
            chk("t3_sat4", q4[0].s, 1);
        end
        if (q8.size() == 1) begin
            chk("t3_p8", q8[0].p, 32);
            chk("t3_sat8", q8[0].s, 0);
        end

        // asynchronous reset while a result is pending
        do_reset();
        period_t(16);
        period_t(16);
        chk("t4_valid_pre", m8.meas_valid, 1);
        chk("t4_sat4_pre", m4.meas_sat, 1);
        rst = 1'b1;
        #1;
        chk("t4_valid", m8.meas_valid, 0);
        chk("t4_period", m8.meas_period, 0);
        chk("t4_sat4", m4.meas_sat, 0);
        chk("t4_valid4", m4.meas_valid, 0);
        chk("t4_locked", locked8, 0);
        tick();
        rst = 1'b0;
        ready = 1'b1;
        period_t(16);
        idle(4);
        chk("t4_rearm_count", q8.size(), 0);
        chk("t4_rearm_valid", m8.meas_valid, 0);

        // transfer on the same edge as the next capture (periods 20 then 16)
        do_reset();
        div = 1'b1;
        idle(10);
        div = 1'b0;
        idle(10);
        div = 1'b1;
        idle(8);
        div = 1'b0;
        idle(8);
        div = 1'b1;
        idle(2);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        chk("t5_valid", m8.meas_valid, 1);
        chk("t5_period", m8.meas_period, 16);
        chk("t5_missed", m8.meas_missed, 0);
        chk("t5_first_cnt", q8.size(), 1);
        if (q8.size() >= 1) chk("t5_first_p", q8[0].p, 20);
        idle(3);
        ready = 1'b1;
        idle(3);
        div = 1'b0;
        idle(4);
        chk("t5_count", q8.size(), 2);
        if (q8.size() == 2) begin
            chk("t5_second_p", q8[1].p, 16);
            chk("t5_second_m", q8[1].m, 0);
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
